dac_axis_stream_buffer: RTL and testbench

Elastic AXI4-Stream output stage between the DDS/direct sample source and the RFDC DAC tile's `m00_axis` port. Absorbs short-term rate mismatch and backpressure from the RFDC, primes a programmable number of 256-bit sample words before streaming, and substitutes zeros when starved. It counts underflow and overflow events for the host-visible status registers. Sits directly downstream of the DAC controller's tdata/tvalid mux and directly upstream of the RFDC.

---
 rtl/dac_buffer_pkg.sv | 15 +
 rtl/sync_fifo_fwft.sv | 61 ++++++
 rtl/dac_axis_stream_buffer.sv | 161 ++++++++++++++++
 tb/tb_dac_axis_stream_buffer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_buffer_pkg.sv
// Shared types and default sizing for the DAC AXI4-Stream output buffer.
package dac_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM
  } buf_state_t;

  localparam int DEFAULT_AXIS_DATA_WIDTH = 256;
  localparam int DEFAULT_FIFO_DEPTH      = 16;
  localparam int DEFAULT_PRIME_LEVEL     = 8;
  localparam int DEFAULT_ERR_CNT_WIDTH   = 32;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; the head word is always visible
// on rd_data and occupancy comes from the pointer difference.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  do_write;
  logic                  do_read;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level    = wr_ptr_q - rd_ptr_q;
  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign do_write = wr_en && !full && !clear;
  assign do_read  = rd_en && !empty && !clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_write) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_read)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/dac_axis_stream_buffer.sv
// Elastic AXI4-Stream stage in front of the RFDC DAC: primes a fill level,
// streams one word per cycle, pads with zeros when starved, counts events.
module dac_axis_stream_buffer
  import dac_buffer_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = DEFAULT_AXIS_DATA_WIDTH,
  parameter int FIFO_DEPTH      = DEFAULT_FIFO_DEPTH,
  parameter int PRIME_LEVEL     = DEFAULT_PRIME_LEVEL,
  parameter int ERR_CNT_WIDTH   = DEFAULT_ERR_CNT_WIDTH
) (
  input  logic                            m00_axis_aclk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            flush,
  input  logic                            clear_errors,
  input  logic [AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0]      m00_axis_tdata,
  output logic                            m00_axis_tvalid,
  input  logic                            m00_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]     level,
  output logic [ERR_CNT_WIDTH-1:0]        underflow_count,
  output logic [ERR_CNT_WIDTH-1:0]        overflow_count,
  output logic                            streaming
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  buf_state_t                 state_q, state_d;
  logic [AXIS_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                       tvalid_q, tvalid_d;
  logic [ERR_CNT_WIDTH-1:0]   underflow_q, underflow_d;
  logic [ERR_CNT_WIDTH-1:0]   overflow_q, overflow_d;

  logic                       fifo_clear;
  logic                       fifo_wr;
  logic                       fifo_rd;
  logic [AXIS_DATA_WIDTH-1:0] fifo_dout;
  logic [LW-1:0]              fifo_level;
  logic                       fifo_full;
  logic                       fifo_empty;

  logic                       advance;
  logic                       wr_attempt;
  logic                       overflow_event;
  logic                       underflow_event;

  sync_fifo_fwft #(
    .DATA_WIDTH (AXIS_DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (m00_axis_aclk),
    .rst     (reset),
    .clear   (fifo_clear),
    .wr_en   (fifo_wr),
    .wr_data (s_axis_tdata),
    .rd_en   (fifo_rd),
    .rd_data (fifo_dout),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The DDS source ignores tready, so a valid word at full is lost and counted.
  assign advance        = m00_axis_tready || !tvalid_q;
  assign wr_attempt     = enable && !flush && (state_q != IDLE) && s_axis_tvalid;
  assign fifo_wr        = wr_attempt && !fifo_full;
  assign overflow_event = wr_attempt && fifo_full;

  always_comb begin
    state_d         = state_q;
    tdata_d         = tdata_q;
    tvalid_d        = tvalid_q;
    fifo_clear      = 1'b0;
    fifo_rd         = 1'b0;
    underflow_event = 1'b0;
    if (!enable) begin
      state_d    = IDLE;
      fifo_clear = 1'b1;
      tdata_d    = '0;
      tvalid_d   = 1'b0;
    end else if (flush) begin
      state_d    = PRIME;
      fifo_clear = 1'b1;
      tdata_d    = '0;
      tvalid_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d  = PRIME;
          tdata_d  = '0;
          tvalid_d = 1'b1;
        end
        PRIME: begin
          tvalid_d = 1'b1;
          if (advance) tdata_d = '0;
          if (fifo_level >= LW'(PRIME_LEVEL)) state_d = STREAM;
        end
        STREAM: begin
          tvalid_d = 1'b1;
          if (advance) begin
            if (!fifo_empty) begin
              fifo_rd = 1'b1;
              tdata_d = fifo_dout;
            end else begin
              tdata_d         = '0;
              underflow_event = 1'b1;
              state_d         = PRIME;
            end
          end
        end
        default: begin
          state_d  = IDLE;
          tdata_d  = '0;
          tvalid_d = 1'b0;
        end
      endcase
    end
  end

  // Saturating counters; a clear wins over an increment in the same cycle.
  always_comb begin
    underflow_d = underflow_q;
    overflow_d  = overflow_q;
    if (clear_errors) begin
      underflow_d = '0;
      overflow_d  = '0;
    end else begin
      if (underflow_event && (underflow_q != '1))
        underflow_d = underflow_q + ERR_CNT_WIDTH'(1);
      if (overflow_event && (overflow_q != '1))
        overflow_d = overflow_q + ERR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge m00_axis_aclk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      underflow_q <= '0;
      overflow_q  <= '0;
    end else begin
      state_q     <= state_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  assign s_axis_tready   = (state_q != IDLE) && !fifo_full;
  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tvalid = tvalid_q;
  assign level           = fifo_level;
  assign underflow_count = underflow_q;
  assign overflow_count  = overflow_q;
  assign streaming       = (state_q == STREAM);

endmodule

// File: tb/tb_dac_axis_stream_buffer.sv
// Directed self-checking bench for dac_axis_stream_buffer with hand-derived
// cycle-accurate expectations and an in-order output scoreboard.
module tb_dac_axis_stream_buffer;

  localparam int DW    = 256;
  localparam int DEPTH = 16;
  localparam int PRIME = 8;
  localparam int CW    = 32;
  localparam int LW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          flush;
  logic          clear_errors;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic [LW-1:0] level;
  logic [CW-1:0] underflow_count;
  logic [CW-1:0] overflow_count;
  logic          streaming;

  int            total_checks = 0;
  int            bad_checks   = 0;
  logic          mon_en = 1'b0;
  int            mon_got = 0;
  logic [DW-1:0] mon_exp = '0;
  logic          prev_ok = 1'b0;
  logic          prev_rdy = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always #5 clk = ~clk;

  dac_axis_stream_buffer #(
    .AXIS_DATA_WIDTH (DW),
    .FIFO_DEPTH      (DEPTH),
    .PRIME_LEVEL     (PRIME),
    .ERR_CNT_WIDTH   (CW)
  ) dut (
    .m00_axis_aclk   (clk),
    .reset           (reset),
    .enable          (enable),
    .flush           (flush),
    .clear_errors    (clear_errors),
    .s_axis_tdata    (s_tdata),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tready   (s_tready),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tready (m_tready),
    .level           (level),
    .underflow_count (underflow_count),
    .overflow_count  (overflow_count),
    .streaming       (streaming)
  );

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic fl, input logic clr,
                               input logic vld, input logic [DW-1:0] data,
                               input logic rdy);
    enable       = en;
    flush        = fl;
    clear_errors = clr;
    s_tvalid     = vld;
    s_tdata      = data;
    m_tready     = rdy;
    @(posedge clk);
    #1;
  endtask

  // Output scoreboard: every non-zero word handed to the RFDC must follow in
  // sequence, and a stalled output must not change.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_ok && !prev_rdy) checkOutput("hold", m_tdata, prev_data);
      if (m_tvalid && m_tready && (m_tdata != '0)) begin
        checkOutput("order", m_tdata, mon_exp);
        mon_exp = mon_exp + DW'(1);
        mon_got++;
      end
      prev_ok   = m_tvalid;
      prev_rdy  = m_tready;
      prev_data = m_tdata;
    end else begin
      prev_ok = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    flush        = 1'b0;
    clear_errors = 1'b0;
    s_tvalid     = 1'b0;
    s_tdata      = '0;
    m_tready     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] reset values");
    checkOutput("rst tvalid", DW'(m_tvalid), DW'(0));
    checkOutput("rst tdata", m_tdata, DW'(0));
    checkOutput("rst s_tready", DW'(s_tready), DW'(0));
    checkOutput("rst level", DW'(level), DW'(0));
    checkOutput("rst underflow", DW'(underflow_count), DW'(0));
    checkOutput("rst overflow", DW'(overflow_count), DW'(0));
    checkOutput("rst streaming", DW'(streaming), DW'(0));

    $display("[TB] prime then stream 8 words, then starve");
    applyStimulus(1, 0, 0, 0, DW'(0), 1);
    checkOutput("t1 prime tvalid", DW'(m_tvalid), DW'(1));
    checkOutput("t1 prime s_tready", DW'(s_tready), DW'(1));
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 0, 1, DW'(i + 1), 1);
      checkOutput("t1 prime zero", m_tdata, DW'(0));
    end
    checkOutput("t1 level", DW'(level), DW'(8));
    checkOutput("t1 still prime", DW'(streaming), DW'(0));
    applyStimulus(1, 0, 0, 0, DW'(0), 1);
    checkOutput("t1 streaming", DW'(streaming), DW'(1));
    checkOutput("t1 zero before data", m_tdata, DW'(0));
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 0, 0, DW'(0), 1);
      checkOutput("t1 data", m_tdata, DW'(i + 1));
    end
    applyStimulus(1, 0, 0, 0, DW'(0), 1);
    checkOutput("t1 pad zero", m_tdata, DW'(0));
    checkOutput("t1 underflow", DW'(underflow_count), DW'(1));
    checkOutput("t1 back to prime", DW'(streaming), DW'(0));

    $display("[TB] toggling tready with continuous input");
    mon_exp = DW'(32'h101);
    mon_got = 0;
    mon_en  = 1'b1;
    for (int i = 0; i < 16; i++)
      applyStimulus(1, 0, 0, 1, DW'(32'h101 + i), (i % 2) == 0);
    for (int i = 0; i < 80 && mon_got < 16; i++)
      applyStimulus(1, 0, 0, 0, DW'(0), (i % 2) == 0);
    checkOutput("t2 count", DW'(mon_got), DW'(16));
    repeat (4) applyStimulus(1, 0, 0, 0, DW'(0), 1);
    mon_en = 1'b0;
    checkOutput("t2 underflow", DW'(underflow_count), DW'(2));
    checkOutput("t2 overflow", DW'(overflow_count), DW'(0));

    $display("[TB] backpressure: 20 words into depth 16");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 0, 1, DW'(32'h201 + i), 0);
      if (i == 14) begin
        checkOutput("t3 level15", DW'(level), DW'(15));
        checkOutput("t3 s_tready15", DW'(s_tready), DW'(1));
      end
      if (i == 15) begin
        checkOutput("t3 level16", DW'(level), DW'(16));
        checkOutput("t3 s_tready16", DW'(s_tready), DW'(0));
      end
    end
    checkOutput("t3 overflow", DW'(overflow_count), DW'(4));
    checkOutput("t3 level full", DW'(level), DW'(16));
    checkOutput("t3 streaming", DW'(streaming), DW'(1));
    checkOutput("t3 frozen tdata", m_tdata, DW'(0));
    mon_exp = DW'(32'h201);
    mon_got = 0;
    mon_en  = 1'b1;
    for (int i = 0; i < 40 && mon_got < 16; i++)
      applyStimulus(1, 0, 0, 0, DW'(0), 1);
    checkOutput("t3 count", DW'(mon_got), DW'(16));
    repeat (3) applyStimulus(1, 0, 0, 0, DW'(0), 1);
    mon_en = 1'b0;
    checkOutput("t3 underflow", DW'(underflow_count), DW'(3));
    checkOutput("t3 overflow kept", DW'(overflow_count), DW'(4));

    $display("[TB] flush mid-stream with input word");
    for (int i = 0; i < 10; i++)
      applyStimulus(1, 0, 0, 1, DW'(32'h301 + i), 1);
    checkOutput("t4 streaming", DW'(streaming), DW'(1));
    checkOutput("t4 first word", m_tdata, DW'(32'h301));
    applyStimulus(1, 1, 0, 1, DW'(32'h3ff), 1);
    checkOutput("t4 level", DW'(level), DW'(0));
    checkOutput("t4 prime", DW'(streaming), DW'(0));
    checkOutput("t4 tdata", m_tdata, DW'(0));
    checkOutput("t4 tvalid", DW'(m_tvalid), DW'(1));
    checkOutput("t4 overflow", DW'(overflow_count), DW'(4));
    applyStimulus(1, 0, 0, 0, DW'(0), 1);
    checkOutput("t4 level after", DW'(level), DW'(0));

    $display("[TB] enable drop mid-stream");
    for (int i = 0; i < 10; i++)
      applyStimulus(1, 0, 0, 1, DW'(32'h401 + i), 1);
    checkOutput("t5 streaming", DW'(streaming), DW'(1));
    checkOutput("t5 first word", m_tdata, DW'(32'h401));
    applyStimulus(0, 0, 0, 0, DW'(0), 1);
    checkOutput("t5 tvalid", DW'(m_tvalid), DW'(0));
    checkOutput("t5 tdata", m_tdata, DW'(0));
    checkOutput("t5 idle", DW'(streaming), DW'(0));
    checkOutput("t5 level", DW'(level), DW'(0));
    checkOutput("t5 s_tready", DW'(s_tready), DW'(0));
    checkOutput("t5 underflow", DW'(underflow_count), DW'(3));
    checkOutput("t5 overflow", DW'(overflow_count), DW'(4));

    $display("[TB] async reset between edges");
    applyStimulus(1, 0, 0, 0, DW'(0), 1);
    for (int i = 0; i < 10; i++)
      applyStimulus(1, 0, 0, 1, DW'(32'h501 + i), 1);
    checkOutput("t6 streaming", DW'(streaming), DW'(1));
    checkOutput("t6 first word", m_tdata, DW'(32'h501));
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6 tvalid", DW'(m_tvalid), DW'(0));
    checkOutput("t6 tdata", m_tdata, DW'(0));
    checkOutput("t6 s_tready", DW'(s_tready), DW'(0));
    checkOutput("t6 level", DW'(level), DW'(0));
    checkOutput("t6 underflow", DW'(underflow_count), DW'(0));
    checkOutput("t6 overflow", DW'(overflow_count), DW'(0));
    checkOutput("t6 streaming off", DW'(streaming), DW'(0));
    enable   = 1'b0;
    s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] clear_errors colliding with overflow");
    applyStimulus(1, 0, 0, 0, DW'(0), 0);
    for (int i = 0; i < 17; i++)
      applyStimulus(1, 0, 0, 1, DW'(32'h601 + i), 0);
    checkOutput("t7 overflow", DW'(overflow_count), DW'(1));
    checkOutput("t7 level", DW'(level), DW'(16));
    applyStimulus(1, 0, 1, 1, DW'(32'h6ff), 0);
    checkOutput("t7 cleared", DW'(overflow_count), DW'(0));
    applyStimulus(1, 0, 0, 1, DW'(32'h700), 0);
    checkOutput("t7 recount", DW'(overflow_count), DW'(1));

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
